// File: rtl/apb_text_console.sv
// -----------------------------------------------------------------------------
// apb_text_console
//
// Turns a stream of characters into APB write transfers into the VGA character
// generator's APB slave. A text cursor walks the 80x30 cell grid. Each printable
// character is written as {16'b0, colour, code} to cell row*80+col. LF and CR
// only move the cursor. A clear request fills all 2400 cells with spaces in
// CLEAR_COLOR and homes the cursor.
//
// Optional feature (macro APB_CONSOLE_TIMEOUT_EN):
//   When defined, an ACCESS phase that sees no PREADY within TIMEOUT_CYCLES
//   cycles is aborted and counted as an error. The cursor or clear index then
//   advances as if the transfer had completed. When undefined, ACCESS waits
//   for PREADY indefinitely and no counter is built.
//
// Ports:
//   clk_i, rstn_i              clock, asynchronous active-low reset
//   char_valid_i/char_ready_o  character handshake (see below)
//   char_data_i, char_color_i  character code and colour byte
//   clear_i                    screen-clear request, sampled in IDLE
//   busy_o                     transfer or clear in progress
//   cursor_col_o/cursor_row_o  current cursor position
//   err_cnt_o                  saturating count of errored/timed-out writes
//   apb_*                      APB master port (write-only)
//   dbg_state_o                FSM state (0 IDLE, 1 SETUP, 2 ACCESS)
//
// Handshake: a character is consumed on every rising clock edge where
// char_valid_i && char_ready_o. char_ready_o is high only in IDLE, with no
// clear pending or requested, so clear_i wins over a character offered in
// the same cycle.
// -----------------------------------------------------------------------------
module apb_text_console #(
  parameter int          APB_ADDR_WIDTH = 13,
  parameter int          APB_DATA_WIDTH = 32,
  parameter int          COLS           = 80,
  parameter int          ROWS           = 30,
  parameter logic [7:0]  CLEAR_COLOR    = 8'h0F,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      char_valid_i,
  input  logic [7:0]                char_data_i,
  input  logic [7:0]                char_color_i,
  output logic                      char_ready_o,
  input  logic                      clear_i,
  output logic                      busy_o,
  output logic [6:0]                cursor_col_o,
  output logic [4:0]                cursor_row_o,
  output logic [7:0]                err_cnt_o,
  output logic [APB_ADDR_WIDTH-1:0] apb_paddr_o,
  output logic [APB_DATA_WIDTH-1:0] apb_pwdata_o,
  output logic                      apb_pwrite_o,
  output logic                      apb_psel_o,
  output logic                      apb_penable_o,
  input  logic                      apb_pready_i,
  input  logic                      apb_pslverr_i,
  output logic [1:0]                dbg_state_o
);

  localparam logic [11:0] LAST_CELL = 12'(COLS * ROWS - 1);
  localparam logic [APB_DATA_WIDTH-1:0] CLEAR_WORD =
    {{(APB_DATA_WIDTH-16){1'b0}}, CLEAR_COLOR, 8'h20};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  state_e                    state_q,    state_d;
  logic                      clearing_q, clearing_d;
  logic [11:0]               clr_idx_q,  clr_idx_d;
  logic [6:0]                col_q,      col_d;
  logic [4:0]                row_q,      row_d;
  logic [7:0]                err_cnt_q,  err_cnt_d;
  logic [APB_ADDR_WIDTH-1:0] paddr_q,    paddr_d;
  logic [APB_DATA_WIDTH-1:0] pwdata_q,   pwdata_d;

  logic        timeout;
  logic        xfer_done;
  logic        xfer_err;
  logic [11:0] row_ext;
  logic [11:0] cell_addr;
  logic [4:0]  row_next_line;

  // row*80 as (row<<6)+(row<<4); 12 bits hold the largest cell index, 2399.
  assign row_ext       = {7'b0, row_q};
  assign cell_addr     = (row_ext << 6) + (row_ext << 4) + {5'b0, col_q};
  assign row_next_line = (row_q == 5'(ROWS - 1)) ? 5'd0 : row_q + 5'd1;

`ifdef APB_CONSOLE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] to_cnt_q, to_cnt_d;

  // Counts ACCESS cycles without PREADY; cleared whenever ACCESS is left.
  always_comb begin
    to_cnt_d = '0;
    timeout  = 1'b0;
    if (state_q == ST_ACCESS && !apb_pready_i) begin
      if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
        timeout = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + TW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout            = 1'b0;
`endif

  // A transfer ends on PREADY or on an abort; an abort counts as an error.
  assign xfer_done = (state_q == ST_ACCESS) && (apb_pready_i || timeout);
  assign xfer_err  = (apb_pready_i && apb_pslverr_i) || timeout;

  assign char_ready_o = (state_q == ST_IDLE) && !clear_i && !clearing_q;

  always_comb begin
    state_d    = state_q;
    clearing_d = clearing_q;
    clr_idx_d  = clr_idx_q;
    col_d      = col_q;
    row_d      = row_q;
    err_cnt_d  = err_cnt_q;
    paddr_d    = paddr_q;
    pwdata_d   = pwdata_q;

    case (state_q)
      ST_IDLE: begin
        if (clear_i) begin
          clearing_d = 1'b1;
          clr_idx_d  = 12'd0;
          paddr_d    = '0;
          pwdata_d   = CLEAR_WORD;
          state_d    = ST_SETUP;
        end else if (char_valid_i && char_ready_o) begin
          case (char_data_i)
            8'h0A: begin
              col_d = 7'd0;
              row_d = row_next_line;
            end
            8'h0D: begin
              col_d = 7'd0;
            end
            default: begin
              paddr_d  = APB_ADDR_WIDTH'(cell_addr);
              pwdata_d = {{(APB_DATA_WIDTH-16){1'b0}}, char_color_i, char_data_i};
              state_d  = ST_SETUP;
            end
          endcase
        end
      end

      ST_SETUP: begin
        state_d = ST_ACCESS;
      end

      ST_ACCESS: begin
        if (xfer_done) begin
          if (xfer_err && err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
          end
          if (clearing_q) begin
            if (clr_idx_q < LAST_CELL) begin
              // pwdata already holds the clear word for every cell.
              clr_idx_d = clr_idx_q + 12'd1;
              paddr_d   = APB_ADDR_WIDTH'(clr_idx_q + 12'd1);
              state_d   = ST_SETUP;
            end else begin
              clearing_d = 1'b0;
              col_d      = 7'd0;
              row_d      = 5'd0;
              state_d    = ST_IDLE;
            end
          end else begin
            if (col_q == 7'(COLS - 1)) begin
              col_d = 7'd0;
              row_d = row_next_line;
            end else begin
              col_d = col_q + 7'd1;
            end
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= ST_IDLE;
      clearing_q <= 1'b0;
      clr_idx_q  <= 12'd0;
      col_q      <= 7'd0;
      row_q      <= 5'd0;
      err_cnt_q  <= 8'd0;
      paddr_q    <= '0;
      pwdata_q   <= '0;
    end else begin
      state_q    <= state_d;
      clearing_q <= clearing_d;
      clr_idx_q  <= clr_idx_d;
      col_q      <= col_d;
      row_q      <= row_d;
      err_cnt_q  <= err_cnt_d;
      paddr_q    <= paddr_d;
      pwdata_q   <= pwdata_d;
    end
  end

  // APB strobes decode straight from the state register, so a reset drops
  // them asynchronously.
  assign apb_psel_o    = (state_q != ST_IDLE);
  assign apb_penable_o = (state_q == ST_ACCESS);
  assign apb_pwrite_o  = (state_q != ST_IDLE);
  assign apb_paddr_o   = paddr_q;
  assign apb_pwdata_o  = pwdata_q;

  assign busy_o       = (state_q != ST_IDLE) || clearing_q;
  assign cursor_col_o = col_q;
  assign cursor_row_o = row_q;
  assign err_cnt_o    = err_cnt_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_apb_text_console.sv
// -----------------------------------------------------------------------------
// tb_apb_text_console
//
// Bench for apb_text_console with a registered-PREADY APB slave. The reference
// model keeps the cursor as a linear cell position (0..2399) and queues the
// expected {paddr, pwdata} of every write.
// -----------------------------------------------------------------------------
module tb_apb_text_console;

  localparam int AW = 13;
  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic          char_valid = 1'b0;
  logic [7:0]    char_data  = 8'h00;
  logic [7:0]    char_color = 8'h00;
  logic          char_ready;
  logic          clear_req  = 1'b0;
  logic          busy;
  logic [6:0]    cur_col;
  logic [4:0]    cur_row;
  logic [7:0]    err_cnt;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic          pwrite, psel, penable;
  logic          pready, pslverr;
  logic [1:0]    dbg_state;

  apb_text_console dut (
    .clk_i         (clk),
    .rstn_i        (rstn),
    .char_valid_i  (char_valid),
    .char_data_i   (char_data),
    .char_color_i  (char_color),
    .char_ready_o  (char_ready),
    .clear_i       (clear_req),
    .busy_o        (busy),
    .cursor_col_o  (cur_col),
    .cursor_row_o  (cur_row),
    .err_cnt_o     (err_cnt),
    .apb_paddr_o   (paddr),
    .apb_pwdata_o  (pwdata),
    .apb_pwrite_o  (pwrite),
    .apb_psel_o    (psel),
    .apb_penable_o (penable),
    .apb_pready_i  (pready),
    .apb_pslverr_i (pslverr),
    .dbg_state_o   (dbg_state)
  );

  // ---------------- check bookkeeping ----------------
  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // ---------------- APB slave: PREADY one cycle after PENABLE ----------------
  int err_mode = 0;  // 0 never, 1 always, 2 random 1-in-4

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pready  <= 1'b0;
      pslverr <= 1'b0;
    end else if (psel && penable && !pready) begin
      pready  <= 1'b1;
      pslverr <= (err_mode == 1) || (err_mode == 2 && $urandom_range(0, 3) == 0);
    end else begin
      pready  <= 1'b0;
      pslverr <= 1'b0;
    end
  end

  // ---------------- reference model + scoreboard ----------------
  logic [AW+DW-1:0] exp_q[$];
  logic [AW+DW-1:0] exp_w;
  int               pos     = 0;
  int               err_exp = 0;
  int               wr_cnt  = 0;
  logic [AW-1:0]    last_addr;
  logic [AW-1:0]    setup_addr;
  logic [DW-1:0]    setup_data;

  task automatic model_accept(input logic [7:0] code, input logic [7:0] color);
    if (code == 8'h0A) pos = (((pos / 80) + 1) % 30) * 80;
    else if (code == 8'h0D) pos = (pos / 80) * 80;
    else begin
      exp_q.push_back({13'(pos), 16'h0000, color, code});
      pos = (pos + 1) % 2400;
    end
  endtask

  // Samples at the falling edge; a completing ACCESS is visible here because
  // PREADY only changes on rising edges.
  always @(negedge clk) begin
    if (rstn) begin
      if (psel && !penable) begin
        setup_addr = paddr;
        setup_data = pwdata;
        check("pwrite_setup", 32'(pwrite), 1);
      end
      if (psel && penable && pready) begin
        check("paddr_stable", 32'(paddr), 32'(setup_addr));
        check("pwdata_stable", pwdata, setup_data);
        check("wr_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          exp_w = exp_q.pop_front();
          check("wr_addr", 32'(paddr), 32'(exp_w[AW+DW-1:DW]));
          check("wr_data", pwdata, exp_w[DW-1:0]);
        end
        wr_cnt++;
        last_addr = paddr;
        if (pslverr && err_exp < 255) err_exp++;
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic check_cursor(input string name);
    check({name, "_col"}, 32'(cur_col), pos % 80);
    check({name, "_row"}, 32'(cur_row), pos / 80);
  endtask

  // Offers one character, waits for acceptance and, for printable codes, for
  // the write to finish. Returns just after the accepting edge for CR/LF.
  task automatic send_char(input logic [7:0] code, input logic [7:0] color);
    int n;
    n = 0;
    @(negedge clk);
    char_valid = 1'b1;
    char_data  = code;
    char_color = color;
    while (!char_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      check("accept_timeout", 32'(char_ready), 1);
      char_valid = 1'b0;
      return;
    end
    model_accept(code, color);
    @(posedge clk);
    #1 char_valid = 1'b0;
    if (code != 8'h0A && code != 8'h0D) begin
      n = 0;
      @(negedge clk);
      while (busy && n < 200) begin
        @(negedge clk);
        n++;
      end
      check("xfer_done", 32'(busy), 0);
    end
  endtask

  function automatic logic [7:0] rand_printable();
    logic [7:0] c;
    c = 8'($urandom_range(0, 255));
    if (c == 8'h0A || c == 8'h0D) c = 8'h2E;
    return c;
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0]    code;
    logic          wr;
    logic [AW-1:0] addr;
    logic [6:0]    col;
    logic [4:0]    row;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wc0;
    int n;

    tbl[0] = '{8'h0D, 1'b0, 13'd0,   7'd0, 5'd0};
    tbl[1] = '{8'h48, 1'b1, 13'd0,   7'd1, 5'd0};
    tbl[2] = '{8'h0A, 1'b0, 13'd0,   7'd0, 5'd1};
    tbl[3] = '{8'h49, 1'b1, 13'd80,  7'd1, 5'd1};
    tbl[4] = '{8'h4A, 1'b1, 13'd81,  7'd2, 5'd1};
    tbl[5] = '{8'h0D, 1'b0, 13'd0,   7'd0, 5'd1};
    tbl[6] = '{8'h4B, 1'b1, 13'd80,  7'd1, 5'd1};
    tbl[7] = '{8'h0A, 1'b0, 13'd0,   7'd0, 5'd2};
    tbl[8] = '{8'h0A, 1'b0, 13'd0,   7'd0, 5'd3};
    tbl[9] = '{8'h78, 1'b1, 13'd240, 7'd1, 5'd3};

    // ---- reset values ----
    repeat (3) @(negedge clk);
    check("rst_psel", 32'(psel), 0);
    check("rst_penable", 32'(penable), 0);
    check("rst_pwrite", 32'(pwrite), 0);
    check("rst_paddr", 32'(paddr), 0);
    check("rst_pwdata", pwdata, 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_err", 32'(err_cnt), 0);
    check_cursor("rst");
    rstn = 1'b1;
    #1 check("rst_ready", 32'(char_ready), 1);

    // ---- 'A' colour 0x1F: cycle-exact sequence ----
    @(negedge clk);
    char_valid = 1'b1; char_data = 8'h41; char_color = 8'h1F;
    check("a_c0_ready", 32'(char_ready), 1);
    model_accept(8'h41, 8'h1F);
    @(posedge clk);
    #1 char_valid = 1'b0;
    @(negedge clk);
    check("a_c1_psel", 32'(psel), 1);
    check("a_c1_penable", 32'(penable), 0);
    check("a_c1_paddr", 32'(paddr), 0);
    check("a_c1_pwdata", pwdata, 32'h0000_1F41);
    check("a_c1_ready", 32'(char_ready), 0);
    @(negedge clk);
    check("a_c2_penable", 32'(penable), 1);
    check("a_c2_pready", 32'(pready), 0);
    @(negedge clk);
    check("a_c3_penable", 32'(penable), 1);
    check("a_c3_busy", 32'(busy), 1);
    @(negedge clk);
    check("a_c4_psel", 32'(psel), 0);
    check("a_c4_ready", 32'(char_ready), 1);
    check("a_c4_col", 32'(cur_col), 1);
    check("a_c4_row", 32'(cur_row), 0);

    // ---- table: H, LF, I ... ----
    for (int i = 0; i < 10; i++) begin
      wc0 = wr_cnt;
      send_char(tbl[i].code, 8'($urandom_range(0, 255)));
      if (tbl[i].code == 8'h0A || tbl[i].code == 8'h0D) begin
        @(negedge clk);
        check("tbl_ctrl_ready", 32'(char_ready), 1);
        check("tbl_ctrl_psel", 32'(psel), 0);
      end
      check("tbl_wr_cnt", wr_cnt - wc0, 32'(tbl[i].wr));
      if (tbl[i].wr) check("tbl_addr", 32'(last_addr), 32'(tbl[i].addr));
      check("tbl_col", 32'(cur_col), 32'(tbl[i].col));
      check("tbl_row", 32'(cur_row), 32'(tbl[i].row));
    end

    // ---- wrap from (79,29) ----
    send_char(8'h0D, 8'h07);
    while (pos / 80 != 29) send_char(8'h0A, 8'h07);
    for (int i = 0; i < 79; i++) send_char(rand_printable(), 8'($urandom_range(0, 255)));
    check("wrap_pre_col", 32'(cur_col), 79);
    check("wrap_pre_row", 32'(cur_row), 29);
    send_char(8'h5A, 8'h07);
    check("wrap_addr", 32'(last_addr), 2399);
    check("wrap_col", 32'(cur_col), 0);
    check("wrap_row", 32'(cur_row), 0);

    // ---- single slave error ----
    err_mode = 1;
    send_char(8'h45, 8'h07);
    err_mode = 0;
    check("slverr_cnt", 32'(err_cnt), 1);
    check("slverr_col", 32'(cur_col), 1);
    check("slverr_row", 32'(cur_row), 0);

    // ---- randomized stream ----
    err_mode = 2;
    for (int i = 0; i < 300; i++) begin
      n = $urandom_range(0, 9);
      if (n == 0) send_char(8'h0A, 8'h00);
      else if (n == 1) send_char(8'h0D, 8'h00);
      else send_char(rand_printable(), 8'($urandom_range(0, 255)));
      check_cursor("rnd");
    end
    err_mode = 0;
    check("rnd_err", 32'(err_cnt), 32'(err_exp));

    // ---- clear wins over a simultaneous character ----
    @(negedge clk);
    clear_req = 1'b1; char_valid = 1'b1; char_data = 8'h41; char_color = 8'h1F;
    #1 check("clr_ready_low", 32'(char_ready), 0);
    for (int i = 0; i < 2400; i++) exp_q.push_back({13'(i), 32'h0000_0F20});
    pos = 0;
    @(posedge clk);
    #1 clear_req = 1'b0; char_valid = 1'b0;
    check("clr_busy", 32'(busy), 1);
    @(negedge clk);
    check("clr_ready_mid", 32'(char_ready), 0);
    n = 0;
    while (busy && n < 10000) begin
      @(negedge clk);
      n++;
    end
    check("clr_done", 32'(busy), 0);
    check("clr_all_written", exp_q.size(), 0);
    check("clr_col", 32'(cur_col), 0);
    check("clr_row", 32'(cur_row), 0);
    check("clr_ready_after", 32'(char_ready), 1);

    // ---- reset during ACCESS ----
    send_char(8'h31, 8'h07);
    @(negedge clk);
    char_valid = 1'b1; char_data = 8'h52; char_color = 8'h07;
    @(posedge clk);
    #1 char_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_penable", 32'(penable), 1);
    #2 rstn = 1'b0;
    #1;
    check("mid_psel_drop", 32'(psel), 0);
    check("mid_penable_drop", 32'(penable), 0);
    pos = 0;
    err_exp = 0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    #1;
    check("mid_state", 32'(dbg_state), 0);
    check("mid_busy", 32'(busy), 0);
    check("mid_ready", 32'(char_ready), 1);
    check("mid_err", 32'(err_cnt), 0);
    check_cursor("mid");

    // ---- error counter saturation ----
    err_mode = 1;
    for (int i = 0; i < 260; i++) send_char(rand_printable(), 8'h07);
    err_mode = 0;
    check("sat_err", 32'(err_cnt), 255);
    check("sat_err_model", 32'(err_cnt), 32'(err_exp));
    check_cursor("sat");

    repeat (2) @(negedge clk);
    check("final_q_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/apb_text_console.md
# apb_text_console

APB master that turns a stream of characters into write transfers into the VGA character generator's APB slave. It keeps a text cursor over the 80×30 cell grid and writes the character code and colour to the addressed cell. It also handles CR/LF control codes and performs a full-screen clear on request. It sits between a CPU-side or UART-side byte source and the character-generator APB port, so the screen can be driven without a CPU-side APB master.

## Interface
- `APB_ADDR_WIDTH`, 13, APB address width.
- `APB_DATA_WIDTH`, 32, APB data width.
- `COLS`, 80, cells per row.
- `ROWS`, 30, rows per screen.
- `CLEAR_COLOR`, 8'h0F, colour byte used by clear.
- `TIMEOUT_CYCLES`, 16, PREADY timeout (only with `APB_CONSOLE_TIMEOUT_EN`).

Ports:
- `clk_i` in 1: clock.
- `rstn_i` in 1: reset, asynchronous, active-low.
- `char_valid_i` in 1: character offered.
- `char_data_i` in 8: character code.
- `char_color_i` in 8: colour byte.
- `char_ready_o` out 1: character accepted when valid&&ready.
- `clear_i` in 1: request screen clear; sampled in IDLE.
- `busy_o` out 1: transfer or clear in progress.
- `cursor_col_o` out 7: current column.
- `cursor_row_o` out 5: current row.
- `err_cnt_o` out 8: saturating count of errored or timed-out transfers.
- `apb_paddr_o` out APB_ADDR_WIDTH: cell index, row*COLS+col.
- `apb_pwdata_o` out APB_DATA_WIDTH: {16'b0, color, char}.
- `apb_pwrite_o` out 1: constant 1 while `apb_psel_o` is high; 0 otherwise.
- `apb_psel_o` out 1.
- `apb_penable_o` out 1.
- `apb_pready_i` in 1.
- `apb_pslverr_i` in 1.

## Operation
- FSM states: IDLE, SETUP, ACCESS. A `clearing` flag and a 12-bit clear index run alongside the FSM.
- IDLE:
  - `char_ready_o` = !clear_i && !clearing.
  - `clear_i` wins over `char_valid_i` in the same cycle. It sets `clearing`, loads index 0 and goes to SETUP.
  - Accepted 0x0A (LF): col←0, row←row+1, with row wrapping 29→0. No APB transfer; stays in IDLE.
  - Accepted 0x0D (CR): col←0. No APB transfer; stays in IDLE.
  - Any other accepted code: latch paddr = row*80+col and pwdata, then go to SETUP.
- SETUP: psel=1, penable=0. Always goes to ACCESS on the next cycle.
- ACCESS: psel=1, penable=1, held until `apb_pready_i`. On PREADY:
  - If pslverr, err_cnt increments, saturating at 255.
  - Printable path: col←col+1. At col 79 → col 0, row+1. Row 29 wraps to 0; there is no scroll.
  - Clear path: if index<2399, index+1, new paddr/pwdata={16'b0,CLEAR_COLOR,8'h20}, next state SETUP. After 2399: `clearing`←0, cursor←(0,0), next state IDLE.
- PADDR, PWDATA and PWRITE stay stable from SETUP through the completing ACCESS cycle.
- Address arithmetic: row*80 is computed as (row<<6)+(row<<4) into 12 bits. The maximum value, 2399, fits in the address.
- `busy_o` = (state!=IDLE) || clearing.

## Timing
- Reset values:
  - All APB outputs 0; paddr and pwdata 0.
  - `char_ready_o` 1 once reset is released.
  - `busy_o` 0, cursor (0,0), `err_cnt_o` 0.
- Reset mid-transfer: psel and penable drop asynchronously and the transfer is abandoned. A clear in progress is abandoned too.
- Printable character: accepted in cycle 0, SETUP in cycle 1, ACCESS from cycle 2.
  - Against the registered-PREADY slave, ACCESS lasts 2 cycles.
  - The next character can be accepted in cycle 4.
- Control codes take 1 cycle each: back-to-back acceptance is allowed.
- The cursor updates in the cycle after the completing ACCESS cycle.
- Full clear: 2400 × (1 SETUP + ACCESS cycles), about 7200 cycles against the reference slave.

## Configuration
- `APB_CONSOLE_TIMEOUT_EN` defined:
  - A cycle counter runs in ACCESS.
  - If PREADY has not been seen after TIMEOUT_CYCLES ACCESS cycles, the transfer aborts: psel/penable→0, err_cnt+1, and the cursor or clear index advances as if the transfer had completed.
- Not defined: ACCESS waits for PREADY indefinitely, and no counter logic is generated.

## Test plan
- Reset, then send 'A' (0x41) with colour 0x1F → one write, paddr=0, pwdata=0x00001F41; cursor (1,0); next ready at cycle 4.
- Place the cursor at (79,29) and send 'Z' → paddr=2399; cursor wraps to (0,0).
- Send 'H', 0x0A, 'I' → writes at paddr 0 and paddr 80. LF produces no PSEL pulse and takes one cycle.
- Assert clear_i and char_valid_i together → char_ready_o=0; 2400 writes of 0x00000F20 to paddr 0..2399 in order; then busy_o=0 and cursor (0,0).
- Slave returns pslverr=1 on a write → err_cnt_o=1 and the cursor still advances. With the macro defined and PREADY held low, the abort occurs after 16 ACCESS cycles and err_cnt_o increments.
- Assert rstn_i low during ACCESS → psel and penable drop immediately; after release the block is in IDLE with cursor (0,0).
